// File: rtl/store_buffer.sv
// Posted-write buffer: FIFO of word stores drained to the data memory whenever
// no load owns the port, with youngest-match forwarding to loads.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       store_valid_i,
    input  logic [31:0]                store_addr_i,
    input  logic [31:0]                store_data_i,
    output logic                       store_ready_o,
    input  logic                       load_valid_i,
    input  logic [31:0]                load_addr_i,
    output logic                       load_hit_o,
    output logic [31:0]                load_data_o,
    output logic                       mem_write_o,
    output logic [31:0]                mem_addr_o,
    output logic [31:0]                mem_data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic          enq, deq, empty;

    assign empty         = (count_q == '0);
    assign store_ready_o = (count_q != CW'(DEPTH));
    assign enq           = store_valid_i && store_ready_o;
    assign deq           = !empty && !load_valid_i;

    assign empty_o     = empty;
    assign count_o     = count_q;
    assign mem_write_o = deq;
    assign mem_addr_o  = empty ? 32'h0 : {addr_q[head_q], 2'b00};
    assign mem_data_o  = empty ? 32'h0 : data_q[head_q];

    always_comb begin
        count_d = count_q;
        if (enq && !deq)      count_d = count_q + CW'(1);
        else if (!enq && deq) count_d = count_q - CW'(1);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) tail_q <= tail_q + PW'(1);
            if (deq) head_q <= head_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Entry storage is left uncleared; occupancy masks stale contents.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_q[tail_q] <= store_addr_i[31:2];
            data_q[tail_q] <= store_data_i;
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx         = '0;
        load_hit_o  = 1'b0;
        load_data_o = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == load_addr_i[31:2])) begin
                load_hit_o  = 1'b1;
                load_data_o = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based model.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        store_valid_i;
    logic [31:0] store_addr_i, store_data_i;
    logic        store_ready_o;
    logic        load_valid_i;
    logic [31:0] load_addr_i;
    logic        load_hit_o;
    logic [31:0] load_data_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic        empty_o;
    logic [2:0]  count_o;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .store_valid_i(store_valid_i), .store_addr_i(store_addr_i),
        .store_data_i(store_data_i), .store_ready_o(store_ready_o),
        .load_valid_i(load_valid_i), .load_addr_i(load_addr_i),
        .load_hit_o(load_hit_o), .load_data_o(load_data_o),
        .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .empty_o(empty_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check all outputs mid-cycle, then advance the model at the edge.
    task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic lv, input logic [31:0] la);
        logic        e_hit, do_enq, do_deq;
        logic [31:0] e_ld;
        ent_t        ne;
        store_valid_i = sv; store_addr_i = sa; store_data_i = sd;
        load_valid_i  = lv; load_addr_i  = la;
        #4;
        e_hit = 1'b0; e_ld = 32'h0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (!e_hit && q[i].a[31:2] == la[31:2]) begin
                e_hit = 1'b1; e_ld = q[i].d;
            end
        chk("count", 32'(count_o), 32'(q.size()));
        chk("empty", 32'(empty_o), 32'(q.size() == 0));
        chk("ready", 32'(store_ready_o), 32'(q.size() < DEPTH));
        chk("mem_write", 32'(mem_write_o), 32'(q.size() != 0 && !lv));
        chk("mem_addr", mem_addr_o, q.size() != 0 ? {q[0].a[31:2], 2'b00} : 32'h0);
        chk("mem_data", mem_data_o, q.size() != 0 ? q[0].d : 32'h0);
        chk("load_hit", 32'(load_hit_o), 32'(e_hit));
        chk("load_data", load_data_o, e_ld);
        @(posedge clk_i);
        do_deq = (q.size() != 0) && !lv;
        do_enq = sv && (q.size() < DEPTH);
        if (do_deq) void'(q.pop_front());
        if (do_enq) begin
            ne.a = sa; ne.d = sd;
            q.push_back(ne);
        end
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        store_valid_i = 1'b0; store_addr_i = '0; store_data_i = '0;
        load_valid_i = 1'b0; load_addr_i = '0;
        #3;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ready", 32'(store_ready_o), 32'd1);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_mem_write", 32'(mem_write_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 32'h0);
        chk("rst_load_hit", 32'(load_hit_o), 32'd0);
        chk("rst_load_data", load_data_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (2) step(0, 0, 0, 0, 0);

        // Single store then drain
        step(1, 32'h10, 32'hAAAA0001, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Fill under a held load, fifth store ignored, then drain in order
        for (int i = 0; i < 5; i++) step(1, 32'(i * 4), 32'hB000 + 32'(i), 1, 32'h8);
        step(0, 0, 0, 1, 32'h4);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 32'h0);

        // Duplicate address forwarding picks youngest
        step(1, 32'h20, 32'd1, 1, 32'h22);
        step(1, 32'h20, 32'd2, 1, 32'h22);
        step(0, 0, 0, 1, 32'h22);
        step(0, 0, 0, 1, 32'h24);
        step(0, 0, 0, 0, 32'h20);
        step(0, 0, 0, 0, 32'h20);

        // Full buffer, drain while a store is held
        for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(i * 4), 32'hC0 + 32'(i), 1, 0);
        for (int i = 0; i < 4; i++) step(1, 32'h200, 32'hD00 + 32'(i), 0, 32'h200);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);

        // Async reset mid-drain
        step(1, 32'h40, 32'h1, 1, 0);
        step(1, 32'h44, 32'h2, 1, 0);
        store_valid_i = 1'b0; load_valid_i = 1'b0;
        #1;
        chk("pre_rst_write", 32'(mem_write_o), 32'(q.size() != 0));
        rst_i = 1'b1;
        #1;
        chk("async_write", 32'(mem_write_o), 32'd0);
        chk("async_count", 32'(count_o), 32'd0);
        chk("async_empty", 32'(empty_o), 32'd1);
        q.delete();
        #2 rst_i = 1'b0;
        @(posedge clk_i); #1;
        repeat (3) step(0, 0, 0, 0, 32'h40);

        // Random traffic over a small address pool to exercise hits and duplicates
        for (int c = 0; c < 400; c++)
            step($urandom_range(99) < 60, {$urandom_range(7), $urandom_range(3)} & 32'h1F | 32'h300,
                 $urandom, $urandom_range(99) < 30,
                 {$urandom_range(7), $urandom_range(3)} & 32'h1F | 32'h300);
        for (int c = 0; c < 6; c++) step(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
